hci_core_mux_static_ctrl: RTL and testbench

Sequential controller that drives the select of the HCI static multiplexer and owns its request/grant handshake toward the downstream TCDM/interconnect. It accepts channel-switch requests, blocks new transactions, waits until every granted transaction has returned its response, then changes the select. This makes the strictly-alternative use required by the static mux safe without software fencing.

---
 rtl/hci_core_mux_static_ctrl.sv | 135 +++++++++++++
 tb/tb_hci_core_mux_static_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_core_mux_static_ctrl.sv
// Select/handshake controller for the HCI static mux: drains all
// outstanding transactions before moving sel_o to a new channel.
//
// Ports:
//   clk_i, rst_ni (sync, active-low), clear_i (sync soft clear)
//   switch_req_i/switch_sel_i -> switch_ack_o, busy_o, sel_o
//   mux_req_i -> tcdm_req_o ; tcdm_gnt_i -> mux_gnt_o
//   r_valid_i & r_ready_i retire responses ; cnt_o outstanding count
//   err_o sticky protocol error (underflow or bad target)
module hci_core_mux_static_ctrl #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DEFAULT_SEL     = 0,
  localparam int unsigned SW = $clog2(NB_CHAN-1)+1,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          switch_req_i,
  input  logic [SW-1:0] switch_sel_i,
  output logic          switch_ack_o,
  output logic          busy_o,
  output logic [SW-1:0] sel_o,
  input  logic          mux_req_i,
  output logic          mux_gnt_o,
  output logic          tcdm_req_o,
  input  logic          tcdm_gnt_i,
  input  logic          r_valid_i,
  input  logic          r_ready_i,
  output logic [CW-1:0] cnt_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] sel_q;
  logic [SW-1:0] tgt_q;
  logic [CW-1:0] cnt_q;
  logic          pend_q;
  logic          ack_q;
  logic          busy_q;
  logic          err_q;

  logic allow;
  logic below_max;
  logic inc;
  logic dec;
  logic tgt_ok;

  assign below_max = cnt_q < CW'(MAX_OUTSTANDING);

  // In DRAIN only a request already on the bus may complete;
  // new requests stay blocked until the select has moved.
  always_comb begin
    allow = 1'b0;
    unique case (state_q)
      RUN:     allow = below_max;
      DRAIN:   allow = pend_q & below_max;
      SWITCH:  allow = 1'b0;
      default: allow = 1'b0;
    endcase
  end

  assign tcdm_req_o = mux_req_i & allow;
  assign mux_gnt_o  = tcdm_gnt_i & tcdm_req_o;

  assign inc    = tcdm_req_o & tcdm_gnt_i;
  assign dec    = r_valid_i & r_ready_i;
  assign tgt_ok = 32'(tgt_q) < NB_CHAN;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q <= RUN;
      sel_q   <= SW'(DEFAULT_SEL);
      tgt_q   <= SW'(DEFAULT_SEL);
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pend_q <= (tcdm_req_o & ~tcdm_gnt_i)
              | (pend_q & mux_req_i & ~inc);

      if (inc && !dec) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (dec && !inc) begin
        if (cnt_q == '0) err_q <= 1'b1;
        else             cnt_q <= cnt_q - CW'(1);
      end

      ack_q <= 1'b0;

      unique case (state_q)
        RUN: begin
          if (switch_req_i) begin
            tgt_q   <= switch_sel_i;
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          // A grant this cycle adds one more response to wait for.
          if (cnt_q == '0 && !pend_q && !inc) begin
            state_q <= SWITCH;
            ack_q   <= 1'b1;
            if (tgt_ok) sel_q <= tgt_q;
            else        err_q <= 1'b1;
          end
        end
        SWITCH: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign switch_ack_o = ack_q;
  assign busy_o       = busy_q;
  assign sel_o        = sel_q;
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_hci_core_mux_static_ctrl.sv
// Bench for hci_core_mux_static_ctrl: directed vectors, expected
// values queued by the driver and checked by a negedge monitor.
module tb_hci_core_mux_static_ctrl;

  localparam int unsigned NB_CHAN = 3;
  localparam int unsigned MAXO    = 3;
  localparam int unsigned SW      = $clog2(NB_CHAN-1)+1;
  localparam int unsigned CW      = $clog2(MAXO+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          sreq;
  logic [SW-1:0] ssel;
  logic          ack;
  logic          busy;
  logic [SW-1:0] sel;
  logic          mreq;
  logic          mgnt;
  logic          treq;
  logic          tgnt;
  logic          rv;
  logic          rr;
  logic [CW-1:0] cnt;
  logic          err;

  always #5 clk = ~clk;

  hci_core_mux_static_ctrl #(
    .NB_CHAN(NB_CHAN),
    .MAX_OUTSTANDING(MAXO),
    .DEFAULT_SEL(0)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .clear_i(clear),
    .switch_req_i(sreq),
    .switch_sel_i(ssel),
    .switch_ack_o(ack),
    .busy_o(busy),
    .sel_o(sel),
    .mux_req_i(mreq),
    .mux_gnt_o(mgnt),
    .tcdm_req_o(treq),
    .tcdm_gnt_i(tgnt),
    .r_valid_i(rv),
    .r_ready_i(rr),
    .cnt_o(cnt),
    .err_o(err)
  );

  typedef enum int {K_SEL, K_ACK, K_BUSY, K_CNT,
                    K_ERR, K_TREQ, K_MGNT} kind_e;

  typedef struct {
    string name;
    kind_e kind;
    int    exp;
  } chk_t;

  chk_t chk_q[$];
  int   ack_q[$];
  int   n_tot = 0;
  int   n_pass = 0;

  function automatic int got(kind_e k);
    case (k)
      K_SEL:   return int'(sel);
      K_ACK:   return int'(ack);
      K_BUSY:  return int'(busy);
      K_CNT:   return int'(cnt);
      K_ERR:   return int'(err);
      K_TREQ:  return int'(treq);
      default: return int'(mgnt);
    endcase
  endfunction

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      int   g;
      c = chk_q.pop_front();
      g = got(c.kind);
      n_tot++;
      if (g == c.exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", c.name, g, c.exp);
    end
    if (ack === 1'b1) begin
      n_tot++;
      if (ack_q.size() == 0) begin
        $display("FAIL unexpected_ack: got ack sel %0d want no ack",
                 sel);
      end else begin
        int e;
        e = ack_q.pop_front();
        if (int'(sel) == e) n_pass++;
        else $display("FAIL ack_sel: got %0d want %0d", sel, e);
      end
    end
  end

  task automatic ex(string n, kind_e k, int v);
    chk_q.push_back('{n, k, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic m, logic g, logic v, logic r,
                     logic s, logic [SW-1:0] t);
    mreq = m;
    tgnt = g;
    rv   = v;
    rr   = r;
    sreq = s;
    ssel = t;
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    ex("rst_sel", K_SEL, 0);
    ex("rst_cnt", K_CNT, 0);
    ex("rst_err", K_ERR, 0);
    ex("rst_busy", K_BUSY, 0);
    ex("rst_ack", K_ACK, 0);

    // idle switch to 1
    drv(0, 0, 0, 0, 1, 1);
    ack_q.push_back(1);
    step();
    drv(1, 1, 0, 0, 0, 0);
    ex("t1_c1_treq", K_TREQ, 0);
    ex("t1_c1_mgnt", K_MGNT, 0);
    ex("t1_c1_busy", K_BUSY, 1);
    step();
    ex("t1_c2_ack", K_ACK, 1);
    ex("t1_c2_sel", K_SEL, 1);
    ex("t1_c2_treq", K_TREQ, 0);
    ex("t1_c2_cnt", K_CNT, 0);
    step();
    ex("t1_c3_treq", K_TREQ, 1);
    ex("t1_c3_mgnt", K_MGNT, 1);
    ex("t1_c3_busy", K_BUSY, 0);
    ex("t1_c3_ack", K_ACK, 0);
    step();
    drv(0, 0, 1, 1, 0, 0);
    ex("t1_cnt1", K_CNT, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t1_cnt0", K_CNT, 0);

    // three reads outstanding, then switch to 2
    drv(1, 1, 0, 0, 0, 0);
    step();
    step();
    step();
    drv(0, 0, 0, 0, 1, 2);
    ack_q.push_back(2);
    ex("t2_cnt3", K_CNT, 3);
    step();
    drv(1, 1, 0, 0, 0, 0);
    ex("t2_drain_treq", K_TREQ, 0);
    ex("t2_drain_mgnt", K_MGNT, 0);
    ex("t2_drain_busy", K_BUSY, 1);
    step();
    drv(1, 1, 1, 1, 0, 0);
    ex("t2_r1_mgnt", K_MGNT, 0);
    ex("t2_r1_cnt", K_CNT, 3);
    step();
    ex("t2_r2_cnt", K_CNT, 2);
    step();
    ex("t2_r3_cnt", K_CNT, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t2_cnt0_busy", K_BUSY, 1);
    ex("t2_cnt0_ack", K_ACK, 0);
    ex("t2_cnt0_sel", K_SEL, 1);
    step();
    ex("t2_sw_ack", K_ACK, 1);
    ex("t2_sw_sel", K_SEL, 2);
    step();
    ex("t2_run_busy", K_BUSY, 0);

    // pending request when switch accepted
    drv(1, 0, 0, 0, 1, 0);
    ack_q.push_back(0);
    ex("t3_a_treq", K_TREQ, 1);
    ex("t3_a_mgnt", K_MGNT, 0);
    step();
    drv(1, 0, 0, 0, 0, 0);
    ex("t3_pend_treq", K_TREQ, 1);
    ex("t3_pend_busy", K_BUSY, 1);
    step();
    drv(1, 1, 0, 0, 0, 0);
    ex("t3_gnt_treq", K_TREQ, 1);
    ex("t3_gnt_mgnt", K_MGNT, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t3_cnt1", K_CNT, 1);
    ex("t3_hold_busy", K_BUSY, 1);
    step();
    drv(0, 0, 1, 1, 0, 0);
    ex("t3_wait_ack", K_ACK, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t3_cnt0", K_CNT, 0);
    ex("t3_cnt0_ack", K_ACK, 0);
    step();
    ex("t3_sw_ack", K_ACK, 1);
    ex("t3_sw_sel", K_SEL, 0);
    step();
    ex("t3_run_busy", K_BUSY, 0);

    // limit and simultaneous grant/response
    drv(1, 1, 0, 0, 0, 0);
    step();
    step();
    step();
    ex("t4_cnt3", K_CNT, 3);
    ex("t4_full_treq", K_TREQ, 0);
    ex("t4_full_mgnt", K_MGNT, 0);
    drv(1, 1, 1, 1, 0, 0);
    step();
    ex("t4_cnt2", K_CNT, 2);
    ex("t4_both_treq", K_TREQ, 1);
    step();
    drv(0, 0, 1, 1, 0, 0);
    ex("t4_both_cnt", K_CNT, 2);
    step();
    ex("t4_cnt1", K_CNT, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t4_cnt0", K_CNT, 0);
    ex("t4_noerr", K_ERR, 0);

    // invalid target keeps sel and flags error
    drv(0, 0, 0, 0, 1, 3);
    ack_q.push_back(0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    step();
    ex("t5_bad_err", K_ERR, 1);
    ex("t5_bad_sel", K_SEL, 0);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    ex("t5_clr_err", K_ERR, 0);

    // underflow
    drv(0, 0, 1, 1, 0, 0);
    step();
    drv(0, 0, 0, 0, 1, 2);
    ack_q.push_back(2);
    ex("t5_uf_err", K_ERR, 1);
    ex("t5_uf_cnt", K_CNT, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
    step();
    ex("t5_sel2", K_SEL, 2);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    ex("t5_clr_sel", K_SEL, 0);
    ex("t5_clr_err2", K_ERR, 0);

    // reset mid-drain with two outstanding
    drv(1, 1, 0, 0, 0, 0);
    step();
    step();
    drv(0, 0, 0, 0, 1, 1);
    ex("t6_cnt2", K_CNT, 2);
    step();
    drv(0, 0, 0, 0, 0, 0);
    ex("t6_drain_busy", K_BUSY, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ex("t6_rst_busy", K_BUSY, 0);
    ex("t6_rst_cnt", K_CNT, 0);
    ex("t6_rst_sel", K_SEL, 0);
    ex("t6_rst_ack", K_ACK, 0);
    step();
    ex("t6_after_ack", K_ACK, 0);
    step();
    step();
    step();

    n_tot++;
    if (ack_q.size() == 0) n_pass++;
    else $display("FAIL missing_ack: got %0d acks pending want 0",
                  ack_q.size());

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
